// File: rtl/ysyx_24100006_if_id_buf_if.sv
// Bundle between the IFU, the IF/ID instruction buffer, ID and the hazard unit.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// valid never waits on ready, and payload is only meaningful while valid is 1.
interface ysyx_24100006_if_id_buf_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            flush;
    logic            stall_id;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [3:0]      id_rs1;
    logic [3:0]      id_rs2;
    logic            id_rs1_ren;
    logic            id_rs2_ren;
    logic [1:0]      dbg_count;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, stall_id, out_ready,
        output in_ready, out_valid, out_pc, out_inst,
        output id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, dbg_count
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, stall_id, out_ready,
        input  in_ready, out_valid, out_pc, out_inst,
        input  id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, dbg_count
    );
endinterface

// File: rtl/ysyx_24100006_if_id_buf.sv
// Two-entry IF/ID instruction buffer: absorbs {pc, inst} from the IFU, offers the
// oldest entry to ID, and decodes its source registers for the RAW hazard unit.
module ysyx_24100006_if_id_buf #(
    parameter int XLEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_24100006_if_id_buf_if.slave      bus
);
    logic [1:0]      count_q, count_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] pc_d   [2];
    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] inst_d [2];

    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            rs1_ren;
    logic            rs2_ren;

    // in_ready comes from registered count only, so ID backpressure never reaches the IFU.
    always_comb begin
        in_ready  = (count_q != 2'd2);
        out_valid = (count_q != 2'd0) && !bus.stall_id && !bus.flush;
        push      = bus.in_valid && in_ready && !bus.flush;
        pop       = out_valid && bus.out_ready;
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (bus.flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) begin
                pc_d[tail_q]   = bus.in_pc;
                inst_d[tail_q] = bus.in_inst;
                tail_d         = !tail_q;
            end
            if (pop) begin
                head_d = !head_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Decode is gated only by occupancy, not by stall, so hazards are re-checked each cycle.
    always_comb begin
        head_inst = inst_q[head_q];
        opcode    = head_inst[6:0];
        funct3    = head_inst[14:12];
        rs1_ren   = 1'b0;
        rs2_ren   = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_ren = 1'b1;
                rs2_ren = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                rs1_ren = 1'b1;
            end
            7'b1110011: begin
                rs1_ren = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: begin
                rs1_ren = 1'b0;
                rs2_ren = 1'b0;
            end
        endcase
        if (count_q == 2'd0) begin
            rs1_ren = 1'b0;
            rs2_ren = 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = pc_q[head_q];
    assign bus.out_inst   = head_inst;
    assign bus.id_rs1     = head_inst[18:15];
    assign bus.id_rs2     = head_inst[23:20];
    assign bus.id_rs1_ren = rs1_ren;
    assign bus.id_rs2_ren = rs2_ren;
    assign bus.dbg_count  = count_q;
endmodule

// File: tb/tb_ysyx_24100006_if_id_buf.sv
// Directed bench for the IF/ID buffer: a vector table for single-cycle behaviour plus
// hand-written streaming, backpressure and asynchronous-reset sequences.
module tb_ysyx_24100006_if_id_buf;
    localparam logic [31:0] PA = 32'h8000_0000, IA = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] PB = 32'h8000_0004, IB = 32'h0020_81B3;  // add x3,x1,x2
    localparam logic [31:0] PC = 32'h8000_0008, IC = 32'h1234_52B7;  // lui x5,0x12345
    localparam logic [31:0] PD = 32'h8000_000C, ID = 32'h3003_1073;  // csrrw x0,mstatus,x6
    localparam logic [31:0] PE = 32'h8000_0010, IE = 32'h0000_0073;  // ecall
    localparam logic [31:0] PF = 32'h8000_0014, IF_ = 32'h3002_D073; // csrrwi x0,mstatus,5
    localparam logic [31:0] PG = 32'h8000_0018, IG = 32'h0020_A223;  // sw x2,4(x1)
    localparam logic [31:0] PH = 32'h8000_001C, IH = 32'h0008_8093;  // addi x1,x17,0

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fl;
        logic        st;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [3:0]  e_rs1;
        logic [3:0]  e_rs2;
        logic        e_r1;
        logic        e_r2;
        logic [1:0]  e_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [63:0] exp_q [$];
    vec_t vecs [26];

    ysyx_24100006_if_id_buf_if #(.XLEN(32)) bus ();

    ysyx_24100006_if_id_buf #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] inst, logic fl,
                                logic st, logic ordy, logic e_ov, logic e_ir,
                                logic [31:0] e_pc, logic [31:0] e_inst, logic [3:0] e_rs1,
                                logic [3:0] e_rs2, logic e_r1, logic e_r2, logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.inst = inst; v.fl = fl; v.st = st; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic drive(logic iv, logic [31:0] pc, logic [31:0] inst, logic fl, logic st, logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.flush     = fl;
        bus.stall_id  = st;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic chk_outs(string tag, logic ov, logic ir, logic [31:0] pc, logic [31:0] inst,
                            logic [3:0] rs1, logic [3:0] rs2, logic r1, logic r2, logic [1:0] cnt);
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(ov));
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(ir));
        chk({tag, " out_pc"}, 64'(bus.out_pc), 64'(pc));
        chk({tag, " out_inst"}, 64'(bus.out_inst), 64'(inst));
        chk({tag, " id_rs1"}, 64'(bus.id_rs1), 64'(rs1));
        chk({tag, " id_rs2"}, 64'(bus.id_rs2), 64'(rs2));
        chk({tag, " id_rs1_ren"}, 64'(bus.id_rs1_ren), 64'(r1));
        chk({tag, " id_rs2_ren"}, 64'(bus.id_rs2_ren), 64'(r2));
        chk({tag, " count"}, 64'(bus.dbg_count), 64'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
        bus.flush = 1'b0; bus.stall_id = 1'b0; bus.out_ready = 1'b0;

        //            iv  pc  inst fl st ordy | ov ir e_pc e_inst rs1 rs2 r1 r2 cnt
        vecs[0]  = mk(0, 0,  0,   0, 0, 0,  0, 1, 0,  0,   0, 0, 0, 0, 0);
        vecs[1]  = mk(1, PA, IA,  0, 0, 1,  0, 1, 0,  0,   0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,  0,   0, 0, 0,  1, 1, PA, IA,  0, 5, 1, 0, 1);
        vecs[3]  = mk(0, 0,  0,   0, 0, 1,  1, 1, PA, IA,  0, 5, 1, 0, 1);
        vecs[4]  = mk(0, 0,  0,   0, 0, 1,  0, 1, 0,  0,   0, 0, 0, 0, 0);
        vecs[5]  = mk(1, PB, IB,  0, 1, 0,  0, 1, 0,  0,   0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0,  0,   0, 1, 1,  0, 1, PB, IB,  1, 2, 1, 1, 1);
        vecs[7]  = mk(0, 0,  0,   0, 1, 1,  0, 1, PB, IB,  1, 2, 1, 1, 1);
        vecs[8]  = mk(0, 0,  0,   0, 1, 1,  0, 1, PB, IB,  1, 2, 1, 1, 1);
        vecs[9]  = mk(0, 0,  0,   0, 0, 1,  1, 1, PB, IB,  1, 2, 1, 1, 1);
        vecs[10] = mk(1, PC, IC,  0, 0, 0,  0, 1, PA, IA,  0, 5, 0, 0, 0);
        vecs[11] = mk(1, PD, ID,  0, 0, 0,  1, 1, PC, IC,  8, 3, 0, 0, 1);
        vecs[12] = mk(1, PE, IE,  1, 0, 1,  0, 0, PC, IC,  8, 3, 0, 0, 2);
        vecs[13] = mk(0, 0,  0,   0, 0, 0,  0, 1, PC, IC,  8, 3, 0, 0, 0);
        vecs[14] = mk(1, PE, IE,  1, 0, 1,  0, 1, PC, IC,  8, 3, 0, 0, 0);
        vecs[15] = mk(0, 0,  0,   0, 0, 0,  0, 1, PC, IC,  8, 3, 0, 0, 0);
        vecs[16] = mk(1, PF, IF_, 0, 0, 1,  0, 1, PC, IC,  8, 3, 0, 0, 0);
        vecs[17] = mk(1, PG, IG,  0, 0, 1,  1, 1, PF, IF_, 5, 0, 0, 0, 1);
        vecs[18] = mk(1, PH, IH,  0, 0, 1,  1, 1, PG, IG,  1, 2, 1, 1, 1);
        vecs[19] = mk(0, 0,  0,   1, 1, 1,  0, 1, PH, IH,  1, 0, 1, 0, 1);
        vecs[20] = mk(0, 0,  0,   0, 0, 0,  0, 1, PH, IH,  1, 0, 0, 0, 0);
        vecs[21] = mk(1, PD, ID,  0, 0, 0,  0, 1, PH, IH,  1, 0, 0, 0, 0);
        vecs[22] = mk(0, 0,  0,   0, 0, 1,  1, 1, PD, ID,  6, 0, 1, 0, 1);
        vecs[23] = mk(1, PE, IE,  0, 0, 0,  0, 1, PG, IG,  1, 2, 0, 0, 0);
        vecs[24] = mk(0, 0,  0,   0, 0, 1,  1, 1, PE, IE,  0, 0, 0, 0, 1);
        vecs[25] = mk(0, 0,  0,   0, 0, 0,  0, 1, PD, ID,  6, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_outs("in_reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].fl, vecs[i].st, vecs[i].ordy);
            chk_outs($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_pc,
                     vecs[i].e_inst, vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_r1,
                     vecs[i].e_r2, vecs[i].e_cnt);
        end

        // Streaming: 8 pushes back to back, one pop per cycle after a single fill cycle.
        for (int k = 0; k < 12; k++) begin
            logic [31:0] spc;
            logic [31:0] sinst;
            spc   = 32'h0000_1000 + 32'(4 * k);
            sinst = 32'h0000_0093 | (32'(k) << 20);
            drive(k < 8, spc, sinst, 0, 0, 1);
            chk($sformatf("stream%0d in_ready", k), 64'(bus.in_ready), 64'd1);
            chk($sformatf("stream%0d out_valid", k), 64'(bus.out_valid), 64'(k >= 1 && k <= 8));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("stream%0d unexpected", k), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("stream%0d order", k), {bus.out_pc, bus.out_inst}, exp_q.pop_front());
                end
            end
            if (k < 8) exp_q.push_back({spc, sinst});
        end
        chk("stream drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: third push held by IFU until a slot frees at the next edge.
        drive(1, 32'h2000, 32'h0000_0013, 0, 0, 0);
        chk("bp0 in_ready", 64'(bus.in_ready), 64'd1);
        drive(1, 32'h2004, 32'h0000_0013, 0, 0, 0);
        chk("bp1 in_ready", 64'(bus.in_ready), 64'd1);
        drive(1, 32'h2008, 32'h0000_0013, 0, 0, 0);
        chk("bp2 in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp2 count", 64'(bus.dbg_count), 64'd2);
        drive(1, 32'h2008, 32'h0000_0013, 0, 0, 1);
        chk("bp3 in_ready full+pop", 64'(bus.in_ready), 64'd0);
        chk("bp3 out_pc", 64'(bus.out_pc), 64'h2000);
        drive(1, 32'h2008, 32'h0000_0013, 0, 0, 1);
        chk("bp4 in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp4 out_pc", 64'(bus.out_pc), 64'h2004);
        drive(0, 0, 0, 0, 0, 1);
        chk("bp5 out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp5 out_pc", 64'(bus.out_pc), 64'h2008);
        drive(0, 0, 0, 0, 0, 1);
        chk("bp6 out_valid", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset in the middle of a cycle with one entry held.
        drive(1, PB, IB, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_outs("pre_rst", 1, 1, PB, IB, 1, 2, 1, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_outs("post_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
